// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: customised-MTC0 report codes shared by cores and the collector
package mips_cpu_pkg;
  typedef enum logic [1:0] {NOOP = 2'd0, PASS = 2'd1, FAIL = 2'd2, DONE = 2'd3} MTC0Code;
endpackage

// File: rtl/pass_done_collector_if.sv
// pass_done_collector_if: per-channel report inputs and the merged valid/ready log stream
//   in_valid/in_value/in_code : NUM_CH report strobes, values, codes
//   out_valid/out_ready       : merged stream handshake
//   out_ch/out_value/out_code : merged stream payload
interface pass_done_collector_if #(parameter int NUM_CH = 2, parameter int VALUE_W = 16);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0] in_valid;
  logic [NUM_CH*VALUE_W-1:0] in_value;
  mips_cpu_pkg::MTC0Code [NUM_CH-1:0] in_code;
  logic out_valid;
  logic out_ready;
  logic [CH_W-1:0] out_ch;
  logic [VALUE_W-1:0] out_value;
  mips_cpu_pkg::MTC0Code out_code;
  modport master (output in_valid, in_value, in_code, out_ready, input out_valid, out_ch, out_value, out_code);
  modport slave (input in_valid, in_value, in_code, out_ready, output out_valid, out_ch, out_value, out_code);
endinterface

// File: rtl/pass_done_collector.sv
// pass_done_collector: per-channel FIFOs of MTC0 reports drained round-robin, plus pass/fail/done status
//   clk, rst (sync, active-high); bus : report inputs and merged output stream
//   pass_cnt/fail_cnt : saturating per-channel counts; done/overflow : sticky per channel
//   all_done : every channel done; any_fail : some channel reported FAIL
module pass_done_collector import mips_cpu_pkg::*; #(
  parameter int NUM_CH = 2,
  parameter int VALUE_W = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  pass_done_collector_if.slave bus,
  output logic [NUM_CH*CNT_W-1:0] pass_cnt,
  output logic [NUM_CH*CNT_W-1:0] fail_cnt,
  output logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] overflow,
  output logic all_done,
  output logic any_fail
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = VALUE_W + 2;
  logic [EW-1:0] mem [NUM_CH][DEPTH];
  logic [AW:0] wr_ptr [NUM_CH];
  logic [AW:0] rd_ptr [NUM_CH];
  logic [NUM_CH-1:0] empty, full, acc, pop;
  logic [CH_W-1:0] rr_ptr, pick, grant, lock_ch;
  logic [EW-1:0] head;
  logic locked, fire;
  function automatic logic [CH_W-1:0] wrap(input int v);
    return CH_W'(v >= NUM_CH ? v - NUM_CH : v);
  endfunction
  always_comb begin
    any_fail = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      empty[i] = wr_ptr[i] == rd_ptr[i];
      full[i] = (wr_ptr[i] ^ rd_ptr[i]) == {1'b1, {AW{1'b0}}};
      acc[i] = bus.in_valid[i] && bus.in_code[i] != NOOP && !done[i];
      pop[i] = fire && grant == CH_W'(i);
      any_fail = any_fail | (fail_cnt[i*CNT_W +: CNT_W] != '0);
    end
  end
  // descending scan so the channel closest to rr_ptr wins
  always_comb begin
    pick = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (!empty[wrap(int'(rr_ptr) + k)]) pick = wrap(int'(rr_ptr) + k);
  end
  // a stalled grant is pinned so a newly filled channel cannot steal the pending payload
  assign grant = locked ? lock_ch : pick;
  assign head = mem[grant][rd_ptr[grant][AW-1:0]];
  assign bus.out_valid = !empty[grant];
  assign fire = bus.out_valid && bus.out_ready;
  assign bus.out_ch = bus.out_valid ? grant : '0;
  assign bus.out_value = bus.out_valid ? head[EW-1:2] : '0;
  assign bus.out_code = bus.out_valid ? MTC0Code'(head[1:0]) : NOOP;
  assign all_done = &done;
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      locked <= 1'b0;
      lock_ch <= '0;
      done <= '0;
      overflow <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      locked <= bus.out_valid && !bus.out_ready;
      lock_ch <= grant;
      if (fire) rr_ptr <= wrap(int'(grant) + 1);
      for (int i = 0; i < NUM_CH; i++) begin
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (acc[i]) begin
          if (!full[i] || pop[i]) begin
            mem[i][wr_ptr[i][AW-1:0]] <= {bus.in_value[i*VALUE_W +: VALUE_W], bus.in_code[i]};
            wr_ptr[i] <= wr_ptr[i] + 1'b1;
          end else overflow[i] <= 1'b1;
          if (bus.in_code[i] == PASS && pass_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})
            pass_cnt[i*CNT_W +: CNT_W] <= pass_cnt[i*CNT_W +: CNT_W] + 1'b1;
          if (bus.in_code[i] == FAIL && fail_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})
            fail_cnt[i*CNT_W +: CNT_W] <= fail_cnt[i*CNT_W +: CNT_W] + 1'b1;
          if (bus.in_code[i] == DONE) done[i] <= 1'b1;
        end
      end
    end
  end
endmodule
